rmii_rx_frame_ctrl: RTL and testbench
=====================================

// Module: rmii_rx_frame_ctrl
// PURPOSE
//  Frame sequencer behind the MII/RMII nibble->byte receiver, in the rx_clk domain.
//  - Consumes the receiver's byte stream.
//  - Filters each frame on destination MAC address (unicast match, broadcast, or promiscuous).
//  - Checks frame length and rx_er, then forwards accepted frames as a byte stream with last/err flags.
//  - Rejected frames are discarded silently, with a drop pulse.
// PARAMETERS
//  P_MAC_ADDR  48'h0  station address, in received byte order (nibble-swapped per the MII rx format)
//  P_MIN_LEN   64     min legal frame bytes, DA through FCS inclusive
//  P_MAX_LEN   1518   max legal frame bytes, DA through FCS inclusive
// PORTS
//  rx_clk       in   1   receive clock; the only clock
//  rx_rst       in   1   reset, asynchronous, active-high
//  rx_byte      in   8   byte from receiver
//  rx_byte_vld  in   1   rx_byte strobe; qualified by rx_data_vld
//  rx_data_vld  in   1   high for the duration of a frame (after SFD)
//  rx_er        in   1   PHY receive error, synchronous to rx_clk
//  cfg_en       in   1   0: all frames discarded, no drop pulse
//  cfg_promisc  in   1   1: accept any destination address
//  o_byte       out  8   forwarded byte
//  o_vld        out  1   o_byte valid, one cycle per byte; no backpressure
//  o_last       out  1   final byte of frame, coincident with o_vld
//  o_err        out  1   valid with o_last: length violation or rx_er seen in frame
//  o_len        out  11  frame byte count, valid with o_last; saturates at 2047
//  o_drop       out  1   1-cycle pulse per address-rejected or runt-in-address frame
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters and shift register cleared.
//  - Byte accepted: rx_byte_vld & rx_data_vld in the same cycle.
//  - End of frame (EOF): rx_data_vld 1->0.
//  - 6x8 shift register SR; all outputs are registered.
//  - States:
//    - IDLE: on rx_data_vld rising -> ADDR if cfg_en (sampled only here), else DISCARD. Len cleared.
//    - ADDR: shift bytes into SR. On 6th byte, compare {SR, byte} to P_MAC_ADDR / 48'hFFFFFFFFFFFF / cfg_promisc.
//      - Match -> PASS.
//      - No match -> DISCARD, o_drop pulse next cycle.
//      - EOF before 6 bytes -> IDLE, o_drop pulse, no o_vld.
//    - PASS: each accepted byte shifts in; the oldest SR byte appears on o_byte/o_vld the next cycle.
//      Latency = 6 bytes + 1 clk. EOF -> FLUSH.
//    - FLUSH: emit the 6 SR bytes on 6 consecutive clocks.
//      - 6th byte carries o_last, o_err and o_len. -> IDLE.
//      - rx_data_vld rising during FLUSH: that frame is entirely discarded
//        (go DISCARD after flush completes, o_drop pulse).
//    - DISCARD: ignore bytes until EOF -> IDLE.
//  - Length: 11-bit count of accepted bytes incl. address; saturates at 2047.
//    o_err = (len < P_MIN_LEN) | (len > P_MAX_LEN) | rx_er seen while rx_data_vld.
//  - rx_er in ADDR: frame continues; error is reported via o_err.
//  - Simultaneous EOF and byte strobe: the byte is not accepted.
//  - cfg_* changes mid-frame take effect only at the next frame start.
//  - Async reset mid-frame: outputs drop to 0 immediately; no o_last is ever emitted for the truncated frame.
// CONFIGURATION
//  RMII_RX_FRAME_STATS_EN defined:
//    - Adds out ports stat_good[15:0], stat_bad[15:0], stat_drop[15:0].
//    - stat_good: o_last & ~o_err. stat_bad: o_last & o_err. stat_drop: o_drop pulses.
//    - Each counter wraps at 2^16; cleared by rx_rst.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Unicast frame, DA=P_MAC_ADDR, 64 bytes, cfg_en=1
//    -> 64 o_vld bytes in order; o_last on 64th; o_err=0; o_len=64; o_drop never.
//  2 Broadcast DA, 100 bytes -> forwarded, o_len=100, o_err=0.
//    Foreign DA, 100 bytes -> no o_vld; one o_drop pulse.
//    Same foreign DA with cfg_promisc=1 -> forwarded.
//  3 Runt: 4 bytes then EOF -> o_drop, no o_vld.
//    40-byte matching frame -> 40 bytes out, o_last with o_err=1, o_len=40.
//  4 1600-byte matching frame -> o_err=1, o_len=1600.
//    rx_er pulsed on byte 30 of a 64-byte frame -> o_err=1.
//  5 Back-to-back: rx_data_vld re-rises 3 clks after EOF
//    -> first frame flush completes intact; second frame discarded with o_drop.
//    cfg_en=0 -> nothing forwarded, no o_drop.
//  6 rx_rst asserted mid-PASS -> outputs 0 within the same cycle.
//    Next legal frame forwarded correctly.
//    With RMII_RX_FRAME_STATS_EN: counters match (good/bad/drop) after scenarios 1-4.

Source files
------------

// File: rtl/rmii_rx_frame_ctrl.sv
// Receive frame sequencer: DA filtering, length/rx_er checking and forwarding with a 6-byte delay line.
// Optional frame statistics counters are enabled by defining RMII_RX_FRAME_STATS_EN.
//
// state     | meaning
// S_IDLE    | waiting for rx_data_vld to rise
// S_ADDR    | collecting the 6 destination address bytes
// S_PASS    | address accepted, forwarding through the 6-byte delay line
// S_FLUSH   | frame ended, draining the 6 bytes still held in the delay line
// S_DISCARD | frame rejected or disabled, waiting for end of frame
module rmii_rx_frame_ctrl #(
    parameter logic [47:0] P_MAC_ADDR = 48'h0,
    parameter int          P_MIN_LEN  = 64,
    parameter int          P_MAX_LEN  = 1518
) (
    input  logic        rx_clk,
    input  logic        rx_rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_vld,
    input  logic        rx_data_vld,
    input  logic        rx_er,
    input  logic        cfg_en,
    input  logic        cfg_promisc,
    output logic [7:0]  o_byte,
    output logic        o_vld,
    output logic        o_last,
    output logic        o_err,
    output logic [10:0] o_len,
    output logic        o_drop
`ifdef RMII_RX_FRAME_STATS_EN
    ,
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad,
    output logic [15:0] stat_drop
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PASS,
        S_FLUSH,
        S_DISCARD
    } state_t;

    state_t      state;
    logic        dv_q;
    logic [47:0] sr;
    logic [10:0] len;
    logic        er_seen;
    logic        promisc_q;
    logic [2:0]  addr_left;
    logic [2:0]  flush_cnt;
    logic        pend;

    logic        byte_acc;
    logic        dv_rise;
    logic        dv_fall;
    logic [47:0] addr_word;
    logic        addr_hit;
    logic [10:0] len_nxt;
    logic [31:0] len_ext;
    logic        len_bad;

    always_comb begin
        byte_acc  = rx_byte_vld & rx_data_vld;
        dv_rise   = rx_data_vld & ~dv_q;
        dv_fall   = ~rx_data_vld & dv_q;
        addr_word = {sr[39:0], rx_byte};
        addr_hit  = (addr_word == P_MAC_ADDR) | (addr_word == 48'hFFFF_FFFF_FFFF) | promisc_q;
        len_nxt   = (len == 11'h7FF) ? len : len + 11'd1;
        len_ext   = {21'd0, len};
        len_bad   = (len_ext < 32'(P_MIN_LEN)) | (len_ext > 32'(P_MAX_LEN));
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state     <= S_IDLE;
            dv_q      <= 1'b0;
            sr        <= 48'd0;
            len       <= 11'd0;
            er_seen   <= 1'b0;
            promisc_q <= 1'b0;
            addr_left <= 3'd0;
            flush_cnt <= 3'd0;
            pend      <= 1'b0;
            o_byte    <= 8'd0;
            o_vld     <= 1'b0;
            o_last    <= 1'b0;
            o_err     <= 1'b0;
            o_len     <= 11'd0;
            o_drop    <= 1'b0;
        end else begin
            dv_q   <= rx_data_vld;
            o_vld  <= 1'b0;
            o_last <= 1'b0;
            o_err  <= 1'b0;
            o_len  <= 11'd0;
            o_drop <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dv_rise) begin
                        len <= 11'd0;
                        if (cfg_en) begin
                            state     <= S_ADDR;
                            promisc_q <= cfg_promisc;
                            er_seen   <= rx_er;
                            addr_left <= 3'd6;
                            // a byte strobed in the very first cycle is the first DA byte
                            if (byte_acc) begin
                                sr        <= {sr[39:0], rx_byte};
                                addr_left <= 3'd5;
                                len       <= 11'd1;
                            end
                        end else begin
                            state <= S_DISCARD;
                        end
                    end
                end
                S_ADDR: begin
                    if (dv_fall) begin
                        state  <= S_IDLE;
                        o_drop <= 1'b1;
                    end else begin
                        er_seen <= er_seen | (rx_er & rx_data_vld);
                        if (byte_acc) begin
                            sr  <= addr_word;
                            len <= len_nxt;
                            if (addr_left == 3'd1) begin
                                state  <= addr_hit ? S_PASS : S_DISCARD;
                                o_drop <= ~addr_hit;
                            end else begin
                                addr_left <= addr_left - 3'd1;
                            end
                        end
                    end
                end
                S_PASS: begin
                    if (dv_fall) begin
                        state     <= S_FLUSH;
                        flush_cnt <= 3'd5;
                        pend      <= 1'b0;
                    end else begin
                        er_seen <= er_seen | (rx_er & rx_data_vld);
                        if (byte_acc) begin
                            o_vld  <= 1'b1;
                            o_byte <= sr[47:40];
                            sr     <= addr_word;
                            len    <= len_nxt;
                        end
                    end
                end
                S_FLUSH: begin
                    o_vld  <= 1'b1;
                    o_byte <= sr[47:40];
                    sr     <= {sr[39:0], 8'h00};
                    if (dv_rise) pend <= 1'b1;
                    if (flush_cnt == 3'd0) begin
                        o_last <= 1'b1;
                        o_err  <= len_bad | er_seen;
                        o_len  <= len;
                        pend   <= 1'b0;
                        // a frame that started while draining is dropped whole
                        o_drop <= pend | dv_rise;
                        state  <= ((pend | dv_rise) & rx_data_vld) ? S_DISCARD : S_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                S_DISCARD: begin
                    if (dv_fall) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RMII_RX_FRAME_STATS_EN
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            stat_good <= 16'd0;
            stat_bad  <= 16'd0;
            stat_drop <= 16'd0;
        end else begin
            if (o_last & ~o_err) stat_good <= stat_good + 16'd1;
            if (o_last & o_err)  stat_bad  <= stat_bad + 16'd1;
            if (o_drop)          stat_drop <= stat_drop + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rmii_rx_frame_ctrl.sv
// Directed bench for rmii_rx_frame_ctrl: filtering, length/error flags, back-to-back and reset cases.
module tb_rmii_rx_frame_ctrl;

    localparam logic [47:0] MAC     = 48'h02_11_22_33_44_55;
    localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] FOREIGN = 48'h0A_BB_CC_DD_EE_01;

    logic        rx_clk = 1'b0;
    logic        rx_rst;
    logic [7:0]  rx_byte;
    logic        rx_byte_vld;
    logic        rx_data_vld;
    logic        rx_er;
    logic        cfg_en;
    logic        cfg_promisc;
    logic [7:0]  o_byte;
    logic        o_vld;
    logic        o_last;
    logic        o_err;
    logic [10:0] o_len;
    logic        o_drop;
`ifdef RMII_RX_FRAME_STATS_EN
    logic [15:0] stat_good;
    logic [15:0] stat_bad;
    logic [15:0] stat_drop;
`endif

    rmii_rx_frame_ctrl #(
        .P_MAC_ADDR(MAC),
        .P_MIN_LEN (64),
        .P_MAX_LEN (1518)
    ) dut (
        .rx_clk     (rx_clk),
        .rx_rst     (rx_rst),
        .rx_byte    (rx_byte),
        .rx_byte_vld(rx_byte_vld),
        .rx_data_vld(rx_data_vld),
        .rx_er      (rx_er),
        .cfg_en     (cfg_en),
        .cfg_promisc(cfg_promisc),
        .o_byte     (o_byte),
        .o_vld      (o_vld),
        .o_last     (o_last),
        .o_err      (o_err),
        .o_len      (o_len),
        .o_drop     (o_drop)
`ifdef RMII_RX_FRAME_STATS_EN
        ,
        .stat_good  (stat_good),
        .stat_bad   (stat_bad),
        .stat_drop  (stat_drop)
`endif
    );

    always #5 rx_clk = ~rx_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // output monitor, written only here
    logic [7:0] obuf[$];
    int last_cnt    = 0;
    int drop_cnt    = 0;
    int last_pos    = 0;
    int last_len    = 0;
    int last_err    = 0;
    int orphan_last = 0;

    initial begin
        forever begin
            @(negedge rx_clk);
            if (!rx_rst) begin
                if (o_vld) obuf.push_back(o_byte);
                if (o_last) begin
                    last_cnt++;
                    last_pos = obuf.size();
                    last_len = int'(o_len);
                    last_err = int'(o_err);
                    if (!o_vld) orphan_last++;
                end
                if (o_drop) drop_cnt++;
            end
        end
    end

    int snap_bytes, snap_last, snap_drop;

    function automatic logic [7:0] exp_byte(logic [47:0] da, int i);
        if (i < 6) return da[(47 - 8*i) -: 8];
        return 8'((i * 7 + 3) & 255);
    endfunction

    task automatic chk(string tag, int obs, int exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        snap_bytes = obuf.size();
        snap_last  = last_cnt;
        snap_drop  = drop_cnt;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic send_bytes(logic [47:0] da, int n, int er_at);
        for (int i = 0; i < n; i++) begin
            @(posedge rx_clk);
            #1;
            rx_byte     = exp_byte(da, i);
            rx_byte_vld = 1'b1;
            rx_er       = (i == er_at);
            @(posedge rx_clk);
            #1;
            rx_byte_vld = 1'b0;
            rx_er       = 1'b0;
        end
    endtask

    task automatic send_frame(logic [47:0] da, int n, int er_at);
        @(posedge rx_clk);
        #1;
        rx_data_vld = 1'b1;
        send_bytes(da, n, er_at);
        @(posedge rx_clk);
        #1;
        rx_data_vld = 1'b0;
        idle(12);
    endtask

    task automatic check_frame(string tag, logic [47:0] da, int n, int exp_err, int exp_drop);
        int bad;
        bad = 0;
        chk({tag, "_bytes"}, obuf.size() - snap_bytes, n);
        for (int i = 0; i < n; i++) begin
            if (snap_bytes + i < obuf.size()) begin
                if (obuf[snap_bytes + i] !== exp_byte(da, i)) bad++;
            end
        end
        chk({tag, "_data"}, bad, 0);
        chk({tag, "_last"}, last_cnt - snap_last, 1);
        chk({tag, "_lastpos"}, last_pos - snap_bytes, n);
        chk({tag, "_len"}, last_len, n);
        chk({tag, "_err"}, last_err, exp_err);
        chk({tag, "_drop"}, drop_cnt - snap_drop, exp_drop);
    endtask

    task automatic check_none(string tag, int exp_drop);
        chk({tag, "_bytes"}, obuf.size() - snap_bytes, 0);
        chk({tag, "_last"}, last_cnt - snap_last, 0);
        chk({tag, "_drop"}, drop_cnt - snap_drop, exp_drop);
    endtask

    initial begin
        rx_rst      = 1'b1;
        rx_byte     = 8'd0;
        rx_byte_vld = 1'b0;
        rx_data_vld = 1'b0;
        rx_er       = 1'b0;
        cfg_en      = 1'b0;
        cfg_promisc = 1'b0;
        #12;
        chk("reset_vld", int'(o_vld), 0);
        chk("reset_flags", int'({o_last, o_err, o_drop}), 0);
        chk("reset_len", int'(o_len), 0);
        chk("reset_byte", int'(o_byte), 0);
        @(posedge rx_clk);
        #1;
        rx_rst = 1'b0;
        cfg_en = 1'b1;
        idle(3);

        snap(); send_frame(MAC, 64, -1);     check_frame("uni64", MAC, 64, 0, 0);
        snap(); send_frame(BCAST, 100, -1);  check_frame("bcast100", BCAST, 100, 0, 0);
        snap(); send_frame(FOREIGN, 100, -1); check_none("foreign", 1);
        cfg_promisc = 1'b1;
        snap(); send_frame(FOREIGN, 100, -1); check_frame("promisc", FOREIGN, 100, 0, 0);
        cfg_promisc = 1'b0;
        snap(); send_frame(MAC, 4, -1);      check_none("runt4", 1);
        snap(); send_frame(MAC, 40, -1);     check_frame("short40", MAC, 40, 1, 0);
        snap(); send_frame(MAC, 1600, -1);   check_frame("long1600", MAC, 1600, 1, 0);
        snap(); send_frame(MAC, 64, 29);     check_frame("rxer64", MAC, 64, 1, 0);
`ifdef RMII_RX_FRAME_STATS_EN
        chk("stat_good", int'(stat_good), 3);
        chk("stat_bad", int'(stat_bad), 3);
        chk("stat_drop", int'(stat_drop), 2);
`endif

        // second frame rises while the first is still draining
        snap();
        @(posedge rx_clk);
        #1;
        rx_data_vld = 1'b1;
        send_bytes(MAC, 64, -1);
        @(posedge rx_clk);
        #1;
        rx_data_vld = 1'b0;
        repeat (3) @(posedge rx_clk);
        #1;
        rx_data_vld = 1'b1;
        send_bytes(MAC, 64, -1);
        @(posedge rx_clk);
        #1;
        rx_data_vld = 1'b0;
        idle(12);
        check_frame("b2b", MAC, 64, 0, 1);

        cfg_en = 1'b0;
        snap(); send_frame(MAC, 64, -1);     check_none("disabled", 0);
        cfg_en = 1'b1;

        snap();
        @(posedge rx_clk);
        #1;
        rx_data_vld = 1'b1;
        send_bytes(MAC, 20, -1);
        chk("pre_rst_vld", int'(o_vld), 1);
        #1;
        rx_rst = 1'b1;
        #1;
        chk("rst_vld", int'(o_vld), 0);
        chk("rst_byte", int'(o_byte), 0);
        rx_data_vld = 1'b0;
        repeat (3) @(posedge rx_clk);
        #1;
        rx_rst = 1'b0;
        idle(12);
        chk("rst_no_last", last_cnt - snap_last, 0);
        snap(); send_frame(MAC, 64, -1);     check_frame("post_rst", MAC, 64, 0, 0);
        chk("orphan_last", orphan_last, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
